// File: rtl/core_seq_if.sv
// Handshake bundle between the stage sequencer and the rv32im pipeline stages.
// The master side is the sequencer; the slave side is the stage/datapath logic.
interface core_seq_if;
    logic        run_i;
    logic        irq_i;
    logic        fetch_ready_i;
    logic        dec_illegal_i;
    logic        dec_mem_op_i;
    logic        exec_ready_i;
    logic        mem_ready_i;
    logic        wrbk_ready_i;
    logic        state_fetch_o;
    logic        state_decode_o;
    logic        state_exec_o;
    logic        state_mem_o;
    logic        state_wrbk_o;
    logic        state_trap_o;
    logic        trap_irq_o;
    logic [3:0]  trap_cause_o;
    logic        retire_o;
    logic [31:0] instret_o;

    modport master (
        input  run_i, irq_i, fetch_ready_i, dec_illegal_i, dec_mem_op_i,
        input  exec_ready_i, mem_ready_i, wrbk_ready_i,
        output state_fetch_o, state_decode_o, state_exec_o, state_mem_o,
        output state_wrbk_o, state_trap_o, trap_irq_o, trap_cause_o,
        output retire_o, instret_o
    );

    modport slave (
        output run_i, irq_i, fetch_ready_i, dec_illegal_i, dec_mem_op_i,
        output exec_ready_i, mem_ready_i, wrbk_ready_i,
        input  state_fetch_o, state_decode_o, state_exec_o, state_mem_o,
        input  state_wrbk_o, state_trap_o, trap_irq_o, trap_cause_o,
        input  retire_o, instret_o
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle stage sequencer: walks FETCH/DECODE/EXEC/MEM/WRBK, raises traps for
// illegal opcodes, memory timeouts and interrupts, and counts retired instructions.
module core_seq #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    core_seq_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WRBK   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic        mem_op_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] instret_q;
    logic        fetch_q;
    logic        decode_q;
    logic        exec_q;
    logic        mem_q;
    logic        wrbk_q;
    logic        trap_q;
    logic        trap_irq_q;
    logic [3:0]  trap_cause_q;
    logic        trap_irq_d;
    logic [3:0]  trap_cause_d;
    logic        retire;
    logic        mem_timeout;

    assign mem_timeout = (wait_cnt_q == TIMEOUT_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Interrupts are only considered at instruction boundaries (IDLE and the WRBK ack).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.run_i && bus.irq_i) begin
                    state_d = TRAP;
                end else if (bus.run_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.fetch_ready_i) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = bus.dec_illegal_i ? TRAP : EXEC;
            end
            EXEC: begin
                if (bus.exec_ready_i) begin
                    state_d = mem_op_q ? MEM : WRBK;
                end
            end
            MEM: begin
                if (bus.mem_ready_i) begin
                    state_d = WRBK;
                end else if (mem_timeout) begin
                    state_d = TRAP;
                end
            end
            WRBK: begin
                if (bus.wrbk_ready_i) begin
                    if (bus.irq_i) begin
                        state_d = TRAP;
                    end else if (bus.run_i) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TRAP: begin
                state_d = bus.run_i ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The trap cause is chosen by the state the trap is entered from.
    always_comb begin
        trap_cause_d = trap_cause_q;
        trap_irq_d   = trap_irq_q;
        retire       = (state_q == WRBK) && bus.wrbk_ready_i;
        if (state_d == TRAP) begin
            case (state_q)
                DECODE: begin
                    trap_cause_d = 4'd2;
                    trap_irq_d   = 1'b0;
                end
                MEM: begin
                    trap_cause_d = 4'd5;
                    trap_irq_d   = 1'b0;
                end
                default: begin
                    trap_cause_d = 4'd11;
                    trap_irq_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_q      <= 1'b0;
            decode_q     <= 1'b0;
            exec_q       <= 1'b0;
            mem_q        <= 1'b0;
            wrbk_q       <= 1'b0;
            trap_q       <= 1'b0;
            trap_irq_q   <= 1'b0;
            trap_cause_q <= 4'd0;
            mem_op_q     <= 1'b0;
            wait_cnt_q   <= 8'd0;
            instret_q    <= 32'd0;
        end else begin
            fetch_q      <= (state_d == FETCH);
            decode_q     <= (state_d == DECODE);
            exec_q       <= (state_d == EXEC);
            mem_q        <= (state_d == MEM);
            wrbk_q       <= (state_d == WRBK);
            trap_q       <= (state_d == TRAP);
            trap_irq_q   <= trap_irq_d;
            trap_cause_q <= trap_cause_d;
            if (state_q == DECODE && !bus.dec_illegal_i) begin
                mem_op_q <= bus.dec_mem_op_i;
            end
            // Holding the counter at zero outside MEM makes every MEM entry start fresh.
            if (state_q != MEM) begin
                wait_cnt_q <= 8'd0;
            end else if (!bus.mem_ready_i) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.state_fetch_o  = fetch_q;
    assign bus.state_decode_o = decode_q;
    assign bus.state_exec_o   = exec_q;
    assign bus.state_mem_o    = mem_q;
    assign bus.state_wrbk_o   = wrbk_q;
    assign bus.state_trap_o   = trap_q;
    assign bus.trap_irq_o     = trap_irq_q;
    assign bus.trap_cause_o   = trap_cause_q;
    assign bus.retire_o       = retire;
    assign bus.instret_o      = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: directed cycle table, hand-written reset/wrap sequences and a
// randomized instruction stream whose expected stage trace is built per instruction.
module tb_core_seq;

    localparam int C_I = 0;
    localparam int C_F = 1;
    localparam int C_D = 2;
    localparam int C_E = 3;
    localparam int C_M = 4;
    localparam int C_W = 5;
    localparam int C_T = 6;
    localparam int TIMEOUT = 4;

    typedef struct {
        int         code;
        bit         run;
        bit         irq;
        bit         fr;
        bit         ill;
        bit         mop;
        bit         er;
        bit         mr;
        bit         wr;
        bit         ret;
        logic [3:0] cause;
    } vec_t;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_instret;
    vec_t        sched[$];

    core_seq_if bus();

    core_seq #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t cyc(int code, bit run, bit irq, bit fr, bit ill, bit mop,
                                 bit er, bit mr, bit wr, bit ret, int cause);
        vec_t v;
        v.code  = code;
        v.run   = run;
        v.irq   = irq;
        v.fr    = fr;
        v.ill   = ill;
        v.mop   = mop;
        v.er    = er;
        v.mr    = mr;
        v.wr    = wr;
        v.ret   = ret;
        v.cause = 4'(cause);
        return v;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus.run_i         = v.run;
        bus.irq_i         = v.irq;
        bus.fetch_ready_i = v.fr;
        bus.dec_illegal_i = v.ill;
        bus.dec_mem_op_i  = v.mop;
        bus.exec_ready_i  = v.er;
        bus.mem_ready_i   = v.mr;
        bus.wrbk_ready_i  = v.wr;
        #1;
    endtask

    task automatic check_output(input vec_t v, input string tag, input int idx);
        logic [5:0] got_s;
        logic [5:0] want_s;
        got_s  = {bus.state_trap_o, bus.state_wrbk_o, bus.state_mem_o,
                  bus.state_exec_o, bus.state_decode_o, bus.state_fetch_o};
        want_s = (v.code == C_I) ? 6'd0 : 6'(1 << (v.code - 1));
        check_val($sformatf("%s[%0d].strobes", tag, idx), 32'(got_s), 32'(want_s));
        check_val($sformatf("%s[%0d].retire", tag, idx), 32'(bus.retire_o), 32'(v.ret));
        check_val($sformatf("%s[%0d].instret", tag, idx), bus.instret_o, exp_instret);
        if (v.code == C_T) begin
            check_val($sformatf("%s[%0d].trap", tag, idx),
                      32'({bus.trap_irq_o, bus.trap_cause_o}),
                      32'({v.cause == 4'd11, v.cause}));
        end
        if (v.ret) begin
            exp_instret++;
        end
    endtask

    task automatic run_sched(input string tag);
        for (int i = 0; i < sched.size(); i++) begin
            apply_stimulus(sched[i]);
            check_output(sched[i], tag, i);
        end
        sched.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".strobes"}, 32'({bus.state_trap_o, bus.state_wrbk_o, bus.state_mem_o,
                  bus.state_exec_o, bus.state_decode_o, bus.state_fetch_o}), 32'd0);
        check_val({tag, ".trap"}, 32'({bus.trap_irq_o, bus.trap_cause_o}), 32'd0);
        check_val({tag, ".retire"}, 32'(bus.retire_o), 32'd0);
        check_val({tag, ".instret"}, bus.instret_o, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(cyc(C_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        check_all_zero(tag);
        rst = 1'b0;
        exp_instret = 32'd0;
    endtask

    // One random instruction: expected trace is the stage sequence with per-stage waits.
    task automatic push_random_instr();
        int  fw, ew, mw, ww;
        bit  ill, mop, irq;
        fw  = $urandom_range(0, 2);
        ill = ($urandom_range(0, 7) == 0);
        mop = rb();
        ew  = $urandom_range(0, 2);
        mw  = $urandom_range(0, TIMEOUT + 2);
        ww  = $urandom_range(0, 2);
        irq = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < fw; k++) sched.push_back(cyc(C_F, rb(), rb(), 0, rb(), rb(), rb(), rb(), rb(), 0, 0));
        sched.push_back(cyc(C_F, rb(), rb(), 1, rb(), rb(), rb(), rb(), rb(), 0, 0));
        sched.push_back(cyc(C_D, rb(), rb(), rb(), ill, mop, rb(), rb(), rb(), 0, 0));
        if (ill) begin
            sched.push_back(cyc(C_T, 1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 0, 2));
            return;
        end
        for (int k = 0; k < ew; k++) sched.push_back(cyc(C_E, rb(), rb(), rb(), rb(), rb(), 0, rb(), rb(), 0, 0));
        sched.push_back(cyc(C_E, rb(), rb(), rb(), rb(), rb(), 1, rb(), rb(), 0, 0));
        if (mop) begin
            if (mw > TIMEOUT) begin
                for (int k = 0; k <= TIMEOUT; k++) sched.push_back(cyc(C_M, rb(), rb(), rb(), rb(), rb(), rb(), 0, rb(), 0, 0));
                sched.push_back(cyc(C_T, 1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 0, 5));
                return;
            end
            for (int k = 0; k < mw; k++) sched.push_back(cyc(C_M, rb(), rb(), rb(), rb(), rb(), rb(), 0, rb(), 0, 0));
            sched.push_back(cyc(C_M, rb(), rb(), rb(), rb(), rb(), rb(), 1, rb(), 0, 0));
        end
        for (int k = 0; k < ww; k++) sched.push_back(cyc(C_W, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 0, 0, 0));
        sched.push_back(cyc(C_W, 1, irq, rb(), rb(), rb(), rb(), rb(), 1, 1, 0));
        if (irq) begin
            sched.push_back(cyc(C_T, 1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), 0, 11));
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_instret = 32'd0;
        rst         = 1'b1;

        // Directed table: idle, 10 ALU ops, load with wait, illegal, interrupts, timeout.
        sched.push_back(cyc(C_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_I, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 10; n++) begin
            sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0));
            sched.push_back(cyc(C_D, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0));
            sched.push_back(cyc(C_E, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0));
            sched.push_back(cyc(C_W, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0));
        end
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        sched.push_back(cyc(C_M, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_M, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_M, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        sched.push_back(cyc(C_W, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_T, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        sched.push_back(cyc(C_W, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        sched.push_back(cyc(C_T, 1, 1, 0, 0, 0, 0, 0, 0, 0, 11));
        sched.push_back(cyc(C_F, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        sched.push_back(cyc(C_W, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        sched.push_back(cyc(C_T, 0, 1, 0, 0, 0, 0, 0, 0, 0, 11));
        sched.push_back(cyc(C_I, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_I, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_T, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11));
        sched.push_back(cyc(C_I, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k <= TIMEOUT; k++) sched.push_back(cyc(C_M, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sched.push_back(cyc(C_T, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        sched.push_back(cyc(C_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_reset("reset");
        run_sched("table");

        // Counter wrap: preload the retire counter, then retire one instruction.
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        sched.push_back(cyc(C_I, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        sched.push_back(cyc(C_W, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        sched.push_back(cyc(C_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_sched("wrap");
        check_val("wrap.final", bus.instret_o, 32'd0);

        // Reset in the middle of a memory access aborts it without retire or trap.
        sched.push_back(cyc(C_I, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_F, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_D, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_E, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        sched.push_back(cyc(C_M, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sched.push_back(cyc(C_M, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_sched("pre_abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("abort");
        rst = 1'b0;
        exp_instret = 32'd0;

        do_reset("reset2");
        sched.push_back(cyc(C_I, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 300; n++) push_random_instr();
        run_sched("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
